// File: rtl/sprite_mixer.sv
// Multi-sprite compositor: per-frame position update (x wrap, y clamp),
// fixed-priority colour mix over background, 2-cycle sync delay and overlap flag.
module sprite_mixer #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 32,
  parameter int unsigned SPRITE_H    = 32,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [10:0]                 beam_x,
  input  logic [9:0]                  beam_y,
  input  logic                        valid,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        frame_tick,
  input  logic [NUM_SPRITES-1:0]      sprite_en,
  input  logic [NUM_SPRITES*12-1:0]   sprite_color,
  input  logic [NUM_SPRITES*4-1:0]    delta_x,
  input  logic [NUM_SPRITES*4-1:0]    delta_y,
  input  logic                        load,
  input  logic [2:0]                  load_idx,
  input  logic [10:0]                 load_x,
  input  logic [9:0]                  load_y,
  output logic [3:0]                  vga_r,
  output logic [3:0]                  vga_g,
  output logic [3:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic [NUM_SPRITES*11-1:0]   pos_x,
  output logic [NUM_SPRITES*10-1:0]   pos_y,
  output logic                        collide
);

  localparam int unsigned XW    = 11;
  localparam int unsigned YW    = 10;
  localparam int unsigned Y_MAX = SCREEN_H - SPRITE_H;

  logic [XW-1:0]          px_q [NUM_SPRITES];
  logic [YW-1:0]          py_q [NUM_SPRITES];
  logic [11:0]            sx_c [NUM_SPRITES];
  logic [11:0]            sy_c [NUM_SPRITES];
  logic [11:0]            nx_c [NUM_SPRITES];
  logic [11:0]            ny_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit_c;
  logic [NUM_SPRITES-1:0] hit1_q;
  logic                   v1_q, hs1_q, vs1_q;
  logic [11:0]            pix_c;
  logic                   multi_c;
  logic                   acc_q;

  // Next position per sprite: 12-bit arithmetic, x wraps, y clamps
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sx_c[i] = {1'b0, px_q[i]} + {{8{delta_x[i*4+3]}}, delta_x[i*4 +: 4]};
      sy_c[i] = {2'b0, py_q[i]} + {{8{delta_y[i*4+3]}}, delta_y[i*4 +: 4]};
      nx_c[i] = sx_c[i];
      if (sx_c[i][11])
        nx_c[i] = sx_c[i] + 12'(SCREEN_W);
      else if (sx_c[i] >= 12'(SCREEN_W))
        nx_c[i] = sx_c[i] - 12'(SCREEN_W);
      ny_c[i] = sy_c[i];
      if (sy_c[i][11])
        ny_c[i] = 12'd0;
      else if (sy_c[i] > 12'(Y_MAX))
        ny_c[i] = 12'(Y_MAX);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (rst) begin
        px_q[i] <= XW'(i * 2 * SPRITE_W);
        py_q[i] <= YW'(Y_MAX);
      end else if (load && (load_idx == 3'(i))) begin
        px_q[i] <= load_x;
        py_q[i] <= load_y;
      end else if (frame_tick) begin
        px_q[i] <= nx_c[i][XW-1:0];
        py_q[i] <= ny_c[i][YW-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      pos_x[i*11 +: 11] = px_q[i];
      pos_y[i*10 +: 10] = py_q[i];
    end
  end

  // Widened compares so a sprite near the right/bottom edge clips instead of wrapping
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit_c[i] = sprite_en[i]
              && ({1'b0, beam_x} >= {1'b0, px_q[i]})
              && ({1'b0, beam_x} <  ({1'b0, px_q[i]} + 12'(SPRITE_W)))
              && ({1'b0, beam_y} >= {1'b0, py_q[i]})
              && ({1'b0, beam_y} <  ({1'b0, py_q[i]} + 11'(SPRITE_H)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      hit1_q <= '0;
    end else begin
      v1_q   <= valid;
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      hit1_q <= hit_c;
    end
  end

  // Lowest index wins
  always_comb begin
    pix_c = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit1_q[i]) pix_c = sprite_color[i*12 +: 12];
    end
  end

  assign multi_c = |(hit1_q & (hit1_q - NUM_SPRITES'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs                <= 1'b0;
      vga_vs                <= 1'b0;
      acc_q                 <= 1'b0;
      collide               <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= v1_q ? pix_c : 12'h000;
      vga_hs                <= hs1_q;
      vga_vs                <= vs1_q;
      if (frame_tick) begin
        collide <= acc_q | (v1_q & multi_c);
        acc_q   <= 1'b0;
      end else begin
        acc_q   <= acc_q | (v1_q & multi_c);
      end
    end
  end

endmodule

// File: tb/tb_sprite_mixer.sv
// Bench for sprite_mixer: directed scenarios with literal expectations plus
// randomized frames checked every cycle against a behavioural screen model.
module tb_sprite_mixer;

  localparam int unsigned N = 4;
  localparam int SW = 32, SH = 32, SCW = 640, SCH = 480, YMAX = SCH - SH;
  localparam logic [11:0] BG = 12'h000;

  logic            clk;
  logic            rst;
  logic [10:0]     beam_x;
  logic [9:0]      beam_y;
  logic            valid, hsync_in, vsync_in, frame_tick;
  logic [N-1:0]    sprite_en;
  logic [N*12-1:0] sprite_color;
  logic [N*4-1:0]  delta_x, delta_y;
  logic            load;
  logic [2:0]      load_idx;
  logic [10:0]     load_x;
  logic [9:0]      load_y;
  logic [3:0]      vga_r, vga_g, vga_b;
  logic            vga_hs, vga_vs;
  logic [N*11-1:0] pos_x;
  logic [N*10-1:0] pos_y;
  logic            collide;

  sprite_mixer #(.NUM_SPRITES(N)) dut (
    .clk(clk), .rst(rst), .beam_x(beam_x), .beam_y(beam_y), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_tick(frame_tick),
    .sprite_en(sprite_en), .sprite_color(sprite_color),
    .delta_x(delta_x), .delta_y(delta_y), .load(load), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .pos_x(pos_x), .pos_y(pos_y), .collide(collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: sprite positions, one pixel waiting in the delay line, the pixel on the pins
  int          mx [N];
  int          my [N];
  logic        acc_m, collide_m;
  logic [11:0] s1_col, out_col;
  logic        s1_hs, s1_vs, s1_v, out_hs, out_vs;
  int          s1_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = i * 2 * SW;
      my[i] = YMAX;
    end
    acc_m = 0; collide_m = 0;
    s1_col = 0; s1_hs = 0; s1_vs = 0; s1_v = 0; s1_n = 0;
    out_col = 0; out_hs = 0; out_vs = 0;
  endtask

  // One clock: predict from the screen rules, advance, then compare everything
  task automatic step();
    logic [11:0] e_col;
    int          e_n, bx, by, nx, ny;
    bit          found, set_m;
    e_col = BG; e_n = 0; found = 0;
    bx = int'(beam_x); by = int'(beam_y);
    for (int i = 0; i < N; i++) begin
      if (sprite_en[i] && bx >= mx[i] && bx < mx[i] + SW && by >= my[i] && by < my[i] + SH) begin
        e_n++;
        if (!found) begin
          e_col = sprite_color[i*12 +: 12];
          found = 1;
        end
      end
    end
    if (!valid) e_col = 12'h000;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      set_m   = s1_v && (s1_n >= 2);
      out_col = s1_col; out_hs = s1_hs; out_vs = s1_vs;
      s1_col  = e_col;  s1_hs = hsync_in; s1_vs = vsync_in; s1_v = valid; s1_n = e_n;
      if (frame_tick) begin
        collide_m = acc_m | set_m;
        acc_m     = 0;
      end else begin
        acc_m = acc_m | set_m;
      end
      for (int i = 0; i < N; i++) begin
        if (load && int'(load_idx) == i) begin
          mx[i] = int'(load_x);
          my[i] = int'(load_y);
        end else if (frame_tick) begin
          nx = mx[i] + int'($signed(delta_x[i*4 +: 4]));
          ny = my[i] + int'($signed(delta_y[i*4 +: 4]));
          if (nx < 0) nx += SCW;
          else if (nx >= SCW) nx -= SCW;
          if (ny < 0) ny = 0;
          else if (ny > YMAX) ny = YMAX;
          mx[i] = nx; my[i] = ny;
        end
      end
    end
    #1;
    chk("pixel", 32'({vga_r, vga_g, vga_b}), 32'(out_col));
    chk("syncs", 32'({vga_hs, vga_vs}), 32'({out_hs, out_vs}));
    chk("collide", 32'(collide), 32'(collide_m));
    for (int i = 0; i < N; i++) begin
      chk("pos_x", 32'(pos_x[i*11 +: 11]), 32'(mx[i]));
      chk("pos_y", 32'(pos_y[i*10 +: 10]), 32'(my[i]));
    end
  endtask

  task automatic rand_load(input int pct);
    if (int'($urandom_range(0, 99)) < pct) begin
      load     = 1'b1;
      load_idx = 3'($urandom);
      load_x   = 11'($urandom_range(0, 1023));
      load_y   = 10'($urandom);
    end
  endtask

  task automatic rand_beam();
    int k, bx, by;
    if ($urandom_range(0, 1) == 1) begin
      k  = int'($urandom_range(0, N - 1));
      bx = mx[k] + int'($urandom_range(0, 40)) - 4;
      by = my[k] + int'($urandom_range(0, 40)) - 4;
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      beam_x = 11'(bx);
      beam_y = 10'(by);
    end else begin
      beam_x = 11'($urandom_range(0, 700));
      beam_y = 10'($urandom_range(0, 520));
    end
  endtask

  initial begin
    rst = 1; beam_x = 0; beam_y = 0; valid = 0; hsync_in = 0; vsync_in = 0;
    frame_tick = 0; sprite_en = '0; sprite_color = '0; delta_x = '0; delta_y = '0;
    load = 0; load_idx = 0; load_x = 0; load_y = 0;
    model_reset();
    step(); step();
    rst = 0;

    // Reset state and sync delay
    step();
    for (int i = 0; i < N; i++) begin
      chk("rst_pos_x", 32'(pos_x[i*11 +: 11]), 32'(i * 64));
      chk("rst_pos_y", 32'(pos_y[i*10 +: 10]), 32'd448);
    end
    chk("rst_pixel", 32'({vga_r, vga_g, vga_b}), 32'h0);
    hsync_in = 1; vsync_in = 1; step();
    hsync_in = 0; vsync_in = 0;
    chk("hs_delay1", 32'({vga_hs, vga_vs}), 32'h0);
    step(); chk("hs_delay2", 32'({vga_hs, vga_vs}), 32'h3);
    step(); chk("hs_delay3", 32'({vga_hs, vga_vs}), 32'h0);

    // Single sprite draw and right-edge miss
    load = 1; load_idx = 0; load_x = 11'd10; load_y = 10'd20; step(); load = 0;
    sprite_en = 4'b0001; sprite_color[11:0] = 12'hF00; step(); step();
    valid = 1; beam_x = 11'd10; beam_y = 10'd20; step();
    beam_x = 11'd41; beam_y = 10'd51; step();
    chk("draw_corner_tl", 32'({vga_r, vga_g, vga_b}), 32'hF00);
    beam_x = 11'd42; beam_y = 10'd20; step();
    chk("draw_corner_br", 32'({vga_r, vga_g, vga_b}), 32'hF00);
    valid = 0; step();
    chk("draw_outside", 32'({vga_r, vga_g, vga_b}), 32'h000);
    step();

    // Wrap and clamp
    load = 1; load_idx = 0; load_x = 11'd636; load_y = 10'd445; step(); load = 0;
    delta_x = 16'h0007; delta_y = 16'h0007; frame_tick = 1; step(); frame_tick = 0;
    chk("wrap_right", 32'(pos_x[10:0]), 32'd3);
    chk("clamp_bottom", 32'(pos_y[9:0]), 32'd448);
    load = 1; load_x = 11'd2; load_y = 10'd3; step(); load = 0;
    delta_x = 16'h0008; delta_y = 16'h0008; frame_tick = 1; step(); frame_tick = 0;
    chk("wrap_left", 32'(pos_x[10:0]), 32'd634);
    chk("clamp_top", 32'(pos_y[9:0]), 32'd0);
    delta_x = '0; delta_y = '0;

    // Priority and collision
    sprite_en = 4'b0110; sprite_color[23:12] = 12'hF00; sprite_color[35:24] = 12'h0F0;
    load = 1; load_idx = 1; load_x = 11'd100; load_y = 10'd100; step();
    load_idx = 2; step(); load = 0;
    frame_tick = 1; step(); frame_tick = 0;
    valid = 1; beam_x = 11'd110; beam_y = 10'd110; step();
    valid = 0; step();
    chk("priority", 32'({vga_r, vga_g, vga_b}), 32'hF00);
    frame_tick = 1; step(); frame_tick = 0;
    chk("collide_set", 32'(collide), 32'd1);
    step();
    frame_tick = 1; step(); frame_tick = 0;
    chk("collide_clear", 32'(collide), 32'd0);

    // Load beats frame_tick on the same sprite; others still move
    delta_x = 16'h5001; delta_y = 16'h5002;
    load = 1; load_idx = 3; load_x = 11'd50; load_y = 10'd60; frame_tick = 1; step();
    load = 0; frame_tick = 0; delta_x = '0; delta_y = '0;
    chk("load_wins_x", 32'(pos_x[43:33]), 32'd50);
    chk("load_wins_y", 32'(pos_y[39:30]), 32'd60);
    chk("other_moves_x", 32'(pos_x[10:0]), 32'd635);
    chk("other_moves_y", 32'(pos_y[9:0]), 32'd2);

    // Mid-scanline reset
    sprite_en = 4'b1111; valid = 1; hsync_in = 1; vsync_in = 1;
    beam_x = 11'd105; beam_y = 10'd105; step(); step();
    rst = 1; step(); rst = 0;
    chk("rst_mid_pixel", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_mid_sync", 32'({vga_hs, vga_vs}), 32'h0);
    chk("rst_mid_pos", 32'({pos_x[43:33], pos_y[39:30]}), 32'({11'd192, 10'd448}));
    step();
    chk("rst_mid_pixel2", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_mid_sync2", 32'({vga_hs, vga_vs}), 32'h0);
    valid = 0; hsync_in = 0; vsync_in = 0; step(); step();

    // Randomized frames; colours only change deep in blanking
    for (int f = 0; f < 200; f++) begin
      int len;
      len = int'($urandom_range(20, 60));
      for (int c = 0; c < len; c++) begin
        rand_beam();
        valid    = ($urandom_range(0, 7) != 0);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        if ($urandom_range(0, 15) == 0) sprite_en = N'($urandom);
        rand_load(5);
        rst = ($urandom_range(0, 299) == 0);
        step();
        load = 0; rst = 0;
      end
      valid = 0;
      for (int b = 0; b < 5; b++) begin
        if (b == 2)
          for (int i = 0; i < N; i++) sprite_color[i*12 +: 12] = 12'($urandom);
        if (b == 3) begin
          frame_tick = 1;
          delta_x    = 16'($urandom);
          delta_y    = 16'($urandom);
          rand_load(30);
        end
        step();
        frame_tick = 0; load = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
